// File: rtl/conv_stream_host.sv
// conv_stream_host: stream host that sits opposite a convolution engine on its x/y
// valid/ready channels. It transmits a locally buffered input vector over x and collects
// the engine results over y into a result buffer for readback. An 8-bit LFSR can throttle
// x_valid assertion and y_ready to exercise backpressure deterministically.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load_we/addr/data     x buffer write port (honoured only while idle)
//   start                 begin a run (sampled only while idle)
//   throttle_en           enable LFSR gating of x_valid assertion and y_ready
//   busy, done            run in progress / one-cycle completion pulse
//   x_data/x_valid/x_ready  outbound sample stream
//   y_data/y_valid/y_ready  inbound result stream
//   rd_addr, rd_data      combinational result buffer readback
//   y_count, overflow     results captured this run / sticky extra-beat flag
module conv_stream_host #(
    parameter int unsigned T      = 8,
    parameter int unsigned SIZE_X = 16,
    parameter int unsigned SIZE_F = 4,
    localparam int unsigned NY    = SIZE_X - SIZE_F + 1,
    localparam int unsigned AW    = $clog2(SIZE_X),
    localparam int unsigned RW    = $clog2(NY)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [T-1:0]  load_data,
    input  logic          start,
    input  logic          throttle_en,
    output logic          busy,
    output logic          done,
    output logic [T-1:0]  x_data,
    output logic          x_valid,
    input  logic          x_ready,
    input  logic [T-1:0]  y_data,
    input  logic          y_valid,
    output logic          y_ready,
    input  logic [RW-1:0] rd_addr,
    output logic [T-1:0]  rd_data,
    output logic [RW:0]   y_count,
    output logic          overflow
);

    // x index must be able to hold SIZE_X itself (the "all sent" value).
    localparam int unsigned XIW = $clog2(SIZE_X + 1);
    localparam int unsigned CW  = RW + 1;
    localparam logic [XIW-1:0] XEnd = XIW'(SIZE_X);
    localparam logic [CW-1:0]  YEnd = CW'(NY);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [T-1:0]     xbuf_q [SIZE_X];
    logic [T-1:0]     ybuf_q [NY];
    logic [XIW-1:0]   x_idx_q, x_idx_d;
    logic [CW-1:0]    y_count_q, y_count_d;
    logic             x_valid_q, x_valid_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       lfsr_q;
    logic             x_gate, y_gate;
    logic             x_fire, y_fire, y_store;

    assign x_gate  = lfsr_q[0];
    assign y_gate  = lfsr_q[1];
    assign x_fire  = x_valid_q && x_ready;
    assign y_fire  = y_valid && y_ready;
    assign y_store = y_fire && (y_count_q < YEnd);

    // State and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            x_idx_q    <= '0;
            y_count_q  <= '0;
            x_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
            lfsr_q     <= 8'hA5;
        end else begin
            state_q    <= state_d;
            x_idx_q    <= x_idx_d;
            y_count_q  <= y_count_d;
            x_valid_q  <= x_valid_d;
            overflow_q <= overflow_d;
            // Fibonacci, taps 8,6,5,4; free-running in every state.
            lfsr_q     <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Buffers carry no reset; their contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (!reset && state_q == StIdle && load_we) begin
            xbuf_q[load_addr] <= load_data;
        end
        if (!reset && y_store) begin
            ybuf_q[y_count_q[RW-1:0]] <= y_data;
        end
    end

    // Datapath next-state: indices, counters and the registered x_valid.
    always_comb begin
        x_idx_d    = x_idx_q;
        y_count_d  = y_count_q;
        overflow_d = overflow_q;
        x_valid_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_idx_d    = '0;
                    y_count_d  = '0;
                    overflow_d = 1'b0;
                    x_valid_d  = !throttle_en || x_gate;
                end
            end
            StRun: begin
                if (x_fire) x_idx_d = x_idx_q + 1'b1;
                if (y_store) begin
                    y_count_d = y_count_q + 1'b1;
                end else if (y_fire) begin
                    overflow_d = 1'b1;
                end
                // A pending x beat is held until taken; the throttle only delays assertion.
                if (x_valid_q && !x_ready) begin
                    x_valid_d = 1'b1;
                end else begin
                    x_valid_d = (x_idx_d < XEnd) && (!throttle_en || x_gate);
                end
            end
            default: ;
        endcase
    end

    // FSM next-state; completion looks at counts after this cycle's transfers.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (x_idx_d == XEnd && y_count_d == YEnd) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
        y_ready  = (state_q == StRun) && (!throttle_en || y_gate);
        x_valid  = x_valid_q;
        y_count  = y_count_q;
        overflow = overflow_q;
        x_data   = '0;
        if (state_q == StRun && x_idx_q < XEnd) begin
            x_data = xbuf_q[x_idx_q[AW-1:0]];
        end
        rd_data = '0;
        if ({1'b0, rd_addr} < YEnd) begin
            rd_data = ybuf_q[rd_addr];
        end
    end

endmodule
